psum_decoder_lut: RTL and testbench

- Programmable successor to the fixed partial-sum decoder. It maps each IN_W-bit partial-sum code to a signed OUT_W-bit activation through a runtime-loadable, double-buffered lookup table.
- Processes CHANNEL_NUM x MACRO_NUM codes per beat through a 2-stage valid/ready pipeline.
- Sits between the Partial_sum outputs and the next layer's input buffer. Layer-specific tables are loaded by the config bus without halting traffic.

---
 rtl/psum_dec_pkg.sv | 30 +++
 rtl/psum_dec_lut_bank.sv | 58 +++++
 rtl/psum_decoder_lut.sv | 150 +++++++++++++++
 tb/tb_psum_decoder_lut.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_dec_pkg.sv
// Shared types and helpers for the programmable partial-sum decoder.
// Holds the default code/output widths, the table entry type and the
// reset-time default table function def_lut().
package psum_dec_pkg;

   localparam int unsigned PSUM_IN_W  = 5;
   localparam int unsigned PSUM_OUT_W = 4;

   typedef logic signed [PSUM_OUT_W-1:0] lut_entry_t;

   // Default table value for one code:
   // the most negative output, plus (b+1) for every set bit b of the code,
   // clipped to the largest positive output.
   function automatic int def_lut(int unsigned code, int unsigned in_w, int unsigned out_w);
      int hi;
      int acc;
      hi  = int'((32'd1 << (out_w - 32'd1)) - 32'd1);
      acc = -hi - 1;
      for (int unsigned b = 0; b < in_w; b++) begin
         if (((code >> b) & 32'd1) != 32'd0) begin
            acc += int'(b) + 1;
         end
      end
      if (acc > hi) begin
         acc = hi;
      end
      return acc;
   endfunction

endpackage

// File: rtl/psum_dec_lut_bank.sv
// Dual-bank lookup table register file.
// One synchronous write port, N_RD combinational lookup lanes, each lane
// choosing its own bank. Every entry of both banks resets to def_lut().
// Ports:
//   clk, rst_n          clock, async active-low reset
//   we, wbank, waddr,   write strobe, target bank, entry index,
//   wdata               entry value (visible on lookups from the next cycle)
//   rd_bank, rd_code    per-lane bank select and code
//   rd_data_c           per-lane looked-up entry (combinational)
module psum_dec_lut_bank
   import psum_dec_pkg::*;
#(
   parameter int unsigned IN_W  = PSUM_IN_W,
   parameter int unsigned OUT_W = PSUM_OUT_W,
   parameter int unsigned N_RD  = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic                             wbank,
   input  logic [IN_W-1:0]                  waddr,
   input  logic [OUT_W-1:0]                 wdata,
   input  logic [N_RD-1:0]                  rd_bank,
   input  logic [N_RD-1:0][IN_W-1:0]        rd_code,
   output logic [N_RD-1:0][OUT_W-1:0]       rd_data_c
);

   localparam int unsigned DEPTH = 32'd1 << IN_W;

   logic [1:0][DEPTH-1:0][OUT_W-1:0] mem;

   // One register per entry so each can carry its own reset value.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar k = 0; k < int'(DEPTH); k++) begin : g_ent
         localparam int unsigned     CODE = k;
         localparam logic            BANK = 1'(b);
         localparam logic [IN_W-1:0] ADDR = IN_W'(k);

         logic [OUT_W-1:0] entry_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_q <= OUT_W'(def_lut(CODE, IN_W, OUT_W));
            end else if (we && (wbank == BANK) && (waddr == ADDR)) begin
               entry_q <= wdata;
            end
         end

         assign mem[b][k] = entry_q;
      end
   end

   // Lookup lanes: plain muxes over the registered entries.
   for (genvar i = 0; i < int'(N_RD); i++) begin : g_rd
      assign rd_data_c[i] = mem[rd_bank[i]][rd_code[i]];
   end

endmodule

// File: rtl/psum_decoder_lut.sv
// Programmable partial-sum decoder: maps each IN_W-bit code of a
// CHANNEL_NUM x MACRO_NUM beat to a signed OUT_W-bit value through a
// double-buffered table, in a 2-stage valid/ready pipeline.
// Stage A captures the beat, macro enables and active bank; stage B does
// the lookup and registers data_out.
// Optional build macro PSUM_DEC_READBACK_EN adds a registered table
// read-back port (cfg_re, cfg_rbank -> cfg_rdata).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/data_in  input beat handshake and codes
//   macro_en                   per-macro enable captured with the beat
//   out_valid/out_ready/data_out  output beat handshake and values
//   cfg_we/cfg_addr/cfg_data   write to the shadow (inactive) bank
//   cfg_swap                   toggle the active bank
//   active_bank                bank used for newly accepted beats
module psum_decoder_lut
   import psum_dec_pkg::*;
#(
   parameter int unsigned CHANNEL_NUM = 128,
   parameter int unsigned MACRO_NUM   = 4,
   parameter int unsigned IN_W        = PSUM_IN_W,
   parameter int unsigned OUT_W       = PSUM_OUT_W
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][IN_W-1:0]     data_in,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic signed [CHANNEL_NUM-1:0][MACRO_NUM-1:0][OUT_W-1:0] data_out,
   input  logic [MACRO_NUM-1:0]                                macro_en,
   input  logic                                                cfg_we,
   input  logic [IN_W-1:0]                                     cfg_addr,
   input  logic signed [OUT_W-1:0]                             cfg_data,
   input  logic                                                cfg_swap,
   output logic                                                active_bank
`ifdef PSUM_DEC_READBACK_EN
   ,
   input  logic                                                cfg_re,
   input  logic                                                cfg_rbank,
   output logic [OUT_W-1:0]                                    cfg_rdata
`endif
);

   localparam int unsigned LANES = CHANNEL_NUM * MACRO_NUM;
`ifdef PSUM_DEC_READBACK_EN
   localparam int unsigned RB_LANES = 1;
`else
   localparam int unsigned RB_LANES = 0;
`endif
   localparam int unsigned N_RD = LANES + RB_LANES;

   // Stage A registers
   logic                                             a_valid;
   logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][IN_W-1:0]  a_data;
   logic [MACRO_NUM-1:0]                             a_en;
   logic                                             a_bank;

   logic                                             b_adv;
   logic                                             accept;

   logic [N_RD-1:0]                                  rd_bank;
   logic [N_RD-1:0][IN_W-1:0]                        rd_code;
   logic [N_RD-1:0][OUT_W-1:0]                       rd_data_c;
   logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][OUT_W-1:0] lane_out;

   // Stage B can take a beat unless it is holding one that is not drained.
   assign b_adv    = ~out_valid | out_ready;
   assign in_ready = ~a_valid | b_adv;
   assign accept   = in_valid & in_ready;

   psum_dec_lut_bank #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .N_RD  (N_RD)
   ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (cfg_we),
      .wbank     (~active_bank),
      .waddr     (cfg_addr),
      .wdata     (cfg_data),
      .rd_bank   (rd_bank),
      .rd_code   (rd_code),
      .rd_data_c (rd_data_c)
   );

   // Lane i = c*MACRO_NUM + m looks up stage-A code with the captured bank;
   // disabled macros are forced to zero regardless of the table.
   for (genvar c = 0; c < int'(CHANNEL_NUM); c++) begin : g_ch
      for (genvar m = 0; m < int'(MACRO_NUM); m++) begin : g_mac
         localparam int unsigned L = c * MACRO_NUM + m;
         assign rd_bank[L]     = a_bank;
         assign rd_code[L]     = a_data[c][m];
         assign lane_out[c][m] = a_en[m] ? rd_data_c[L] : '0;
      end
   end

`ifdef PSUM_DEC_READBACK_EN
   // The extra lookup lane serves read-back.
   assign rd_bank[LANES] = cfg_rbank;
   assign rd_code[LANES] = cfg_addr;
`endif

   // Pipeline stages and active bank pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid     <= 1'b0;
         a_data      <= '0;
         a_en        <= '0;
         a_bank      <= 1'b0;
         out_valid   <= 1'b0;
         data_out    <= '0;
         active_bank <= 1'b0;
      end else begin
         if (accept) begin
            a_valid <= 1'b1;
            a_data  <= data_in;
            a_en    <= macro_en;
            a_bank  <= active_bank;
         end else if (b_adv) begin
            a_valid <= 1'b0;
         end

         if (b_adv) begin
            out_valid <= a_valid;
            if (a_valid) begin
               data_out <= lane_out;
            end
         end

         if (cfg_swap) begin
            active_bank <= ~active_bank;
         end
      end
   end

`ifdef PSUM_DEC_READBACK_EN
   // Read-back register; reads the pre-write value when a write hits the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_rdata <= '0;
      end else if (cfg_re) begin
         cfg_rdata <= rd_data_c[LANES];
      end
   end
`endif

endmodule

// File: tb/tb_psum_decoder_lut.sv
// Bench for psum_decoder_lut: a cycle-level behavioural model (two tables,
// an active-bank index and a queue of in-flight beats) is checked against
// the DUT on every negative edge, plus hand-computed literal expectations.
module tb_psum_decoder_lut;
   import psum_dec_pkg::*;

   localparam int CH = 128;
   localparam int MAC = 4;
   localparam int IW = 5;
   localparam int OW = 4;
   localparam int CW = $clog2(CH);
   localparam int MW = $clog2(MAC);

   typedef logic [CH-1:0][MAC-1:0][IW-1:0] in_vec_t;
   typedef logic [CH-1:0][MAC-1:0][OW-1:0] out_vec_t;
   typedef struct {
      int       acc;
      out_vec_t data;
   } beat_t;

   logic                                   clk = 1'b0;
   logic                                   rst_n;
   logic                                   in_valid;
   logic                                   in_ready;
   in_vec_t                                data_in;
   logic                                   out_valid;
   logic                                   out_ready;
   logic signed [CH-1:0][MAC-1:0][OW-1:0]  data_out;
   logic [MAC-1:0]                         macro_en;
   logic                                   cfg_we;
   logic [IW-1:0]                          cfg_addr;
   lut_entry_t                             cfg_data;
   logic                                   cfg_swap;
   logic                                   active_bank;
`ifdef PSUM_DEC_READBACK_EN
   logic                                   cfg_re;
   logic                                   cfg_rbank;
   logic [OW-1:0]                          cfg_rdata;
`endif

   int       n_vec = 0;
   int       n_err = 0;
   int       cyc = 0;
   bit       acc_flag = 1'b0;
   int       tbl [2][32];
   int       act = 0;
   beat_t    q[$];
   out_vec_t out_log[$];

   always #5 clk = ~clk;

   psum_decoder_lut #(
      .CHANNEL_NUM (CH),
      .MACRO_NUM   (MAC),
      .IN_W        (IW),
      .OUT_W       (OW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_in     (data_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .data_out    (data_out),
      .macro_en    (macro_en),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_swap    (cfg_swap),
      .active_bank (active_bank)
`ifdef PSUM_DEC_READBACK_EN
      ,
      .cfg_re      (cfg_re),
      .cfg_rbank   (cfg_rbank),
      .cfg_rdata   (cfg_rdata)
`endif
   );

   // Default table: -8 plus (b+1) per set bit b, capped at +7.
   function automatic int tb_def(int k);
      int acc;
      acc = -8;
      for (int b = 0; b < IW; b++) begin
         if (((k >> b) & 1) != 0) acc += b + 1;
      end
      if (acc > 7) acc = 7;
      return acc;
   endfunction

   function automatic in_vec_t make_vec(int base, int step);
      in_vec_t v;
      for (int c = 0; c < CH; c++) begin
         for (int m = 0; m < MAC; m++) begin
            v[CW'(c)][MW'(m)] = IW'((base + step * (c * MAC + m)) % 32);
         end
      end
      return v;
   endfunction

   function automatic out_vec_t decode(in_vec_t d, logic [MAC-1:0] en, int bank);
      out_vec_t v;
      for (int c = 0; c < CH; c++) begin
         for (int m = 0; m < MAC; m++) begin
            if (en[MW'(m)]) v[CW'(c)][MW'(m)] = OW'(tbl[bank][int'(d[CW'(c)][MW'(m)])]);
            else            v[CW'(c)][MW'(m)] = '0;
         end
      end
      return v;
   endfunction

   function automatic int lane(out_vec_t v, int c, int m);
      logic signed [OW-1:0] e;
      e = v[CW'(c)][MW'(m)];
      return int'(e);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 32; k++) tbl[b][k] = tb_def(k);
      end
      act = 0;
      q.delete();
   endtask

   // Model: a beat accepted in cycle a is shown from cycle a+2 once it is
   // at the head of the in-order queue; with two beats held and the output
   // stalled, nothing new is taken.
   always @(negedge clk) begin
      bit    exp_ov;
      bit    exp_ir;
      beat_t nb;
      if (!rst_n) begin
         model_reset();
         acc_flag = 1'b0;
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_active_bank", int'(active_bank), 0);
         chk("rst_data_out_zero", int'(data_out == '0), 1);
      end else begin
         exp_ov = 1'b0;
         if (q.size() > 0) exp_ov = (q[0].acc + 2 <= cyc);
         exp_ir = !(q.size() == 2 && !out_ready);
         chk("in_ready", int'(in_ready), int'(exp_ir));
         chk("out_valid", int'(out_valid), int'(exp_ov));
         chk("active_bank", int'(active_bank), act);
         if (exp_ov) begin
            n_vec++;
            if (data_out !== q[0].data) begin
               bit shown;
               n_err++;
               shown = 1'b0;
               for (int c = 0; c < CH; c++) begin
                  for (int m = 0; m < MAC; m++) begin
                     if (!shown && lane(data_out, c, m) != lane(q[0].data, c, m)) begin
                        shown = 1'b1;
                        $display("FAIL data_out c=%0d m=%0d: got %0d expected %0d (t=%0t)",
                                 c, m, lane(data_out, c, m), lane(q[0].data, c, m), $time);
                     end
                  end
               end
               if (!shown) $display("FAIL data_out: unknown bits (t=%0t)", $time);
            end
         end
         acc_flag = in_valid && exp_ir;
         if (exp_ov && out_ready) void'(q.pop_front());
         if (acc_flag) begin
            nb.acc  = cyc;
            nb.data = decode(data_in, macro_en, act);
            q.push_back(nb);
         end
         if (cfg_we) tbl[1 - act][int'(cfg_addr)] = int'(cfg_data);
         if (cfg_swap) act = 1 - act;
      end
      cyc++;
   end

   // Delivered beats, in order, for literal checks.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) out_log.push_back(data_out);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_beat(input in_vec_t d, input logic [MAC-1:0] en);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      data_in  = d;
      macro_en = en;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         #1;
         if (acc_flag) done = 1'b1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL drive_beat: beat not accepted within 50 cycles (t=%0t)", $time);
      end
   endtask

   task automatic get_out(output out_vec_t v);
      bit got;
      got = 1'b0;
      v   = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            v   = data_out;
            got = 1'b1;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL get_out: no output beat within 20 cycles (t=%0t)", $time);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      out_vec_t v;
      int       t0;
      int       n_acc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      macro_en  = '1;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      cfg_swap  = 1'b0;
`ifdef PSUM_DEC_READBACK_EN
      cfg_re    = 1'b0;
      cfg_rbank = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Pin the model's default table.
      chk("model_def0", tb_def(0), -8);
      chk("model_def3", tb_def(3), -5);
      chk("model_def31", tb_def(31), 7);

      // Stream codes 0..31 (lane 0 of beat i carries code i), one per cycle.
      out_log.delete();
      t0 = cyc;
      for (int i = 0; i < 32; i++) drive_beat(make_vec(i, 7), '1);
      chk("stream_throughput_cycles", cyc - t0, 32);
      idle(4);
      chk("stream_beat_count", out_log.size(), 32);
      if (out_log.size() == 32) begin
         chk("def_code0", lane(out_log[0], 0, 0), -8);
         chk("def_code4", lane(out_log[4], 0, 0), -5);
         chk("def_code13", lane(out_log[13], 0, 0), 0);
         chk("def_code31", lane(out_log[31], 0, 0), 7);
         chk("def_code7_lane1", lane(out_log[0], 0, 1), -2);
      end

      // Output stall for 5 cycles with input pressure.
      out_log.delete();
      n_acc = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) drive_beat(make_vec(20 + i, 3), '1);
         end
         begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk);
               #1;
               if (acc_flag) n_acc++;
            end
            out_ready = 1'b1;
         end
      join
      idle(4);
      chk("stall_accepts", n_acc, 2);
      chk("stall_beat_count", out_log.size(), 6);
      if (out_log.size() == 6) begin
         chk("stall_first_code20", lane(out_log[0], 0, 0), 0);
         chk("stall_last_code25", lane(out_log[5], 0, 0), 2);
      end

      // Shadow write then swap; the swap-cycle beat still uses the old bank.
      cfg_we   = 1'b1;
      cfg_addr = 5'd5;
      cfg_data = 4'sd6;
      idle(1);
      cfg_we   = 1'b0;
      cfg_swap = 1'b1;
      drive_beat(make_vec(5, 0), '1);
      cfg_swap = 1'b0;
      get_out(v);
      chk("swap_cycle_old_bank", lane(v, 0, 0), -4);
      chk("swap_cycle_old_bank_last", lane(v, CH - 1, MAC - 1), -4);
      drive_beat(make_vec(5, 0), '1);
      get_out(v);
      chk("after_swap_new_bank", lane(v, 0, 0), 6);
      chk("active_after_swap", int'(active_bank), 1);

      // Disabled macros give zero.
      drive_beat(make_vec(31, 0), 4'b1010);
      get_out(v);
      chk("macro_en_m0", lane(v, 0, 0), 0);
      chk("macro_en_m1", lane(v, 0, 1), 7);
      chk("macro_en_m2", lane(v, 64, 2), 0);
      chk("macro_en_m3", lane(v, 127, 3), 7);

      // Write and swap in the same cycle: written bank becomes active.
      cfg_we   = 1'b1;
      cfg_addr = 5'd0;
      cfg_data = -4'sd1;
      cfg_swap = 1'b1;
      idle(1);
      cfg_we   = 1'b0;
      cfg_swap = 1'b0;
      chk("we_swap_active", int'(active_bank), 0);
      drive_beat(make_vec(0, 0), '1);
      get_out(v);
      chk("we_swap_code0", lane(v, 0, 0), -1);

      // Back-to-back swaps toggle every cycle (0 -> 1 -> 0 -> 1).
      cfg_swap = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("b2b_swap", int'(active_bank), (i % 2 == 0) ? 1 : 0);
      end
      cfg_swap = 1'b0;

      // Reset with two beats in flight after the swap.
      drive_beat(make_vec(5, 0), '1);
      drive_beat(make_vec(5, 0), '1);
      chk("pre_rst_out_valid", int'(out_valid), 1);
      chk("pre_rst_code5", lane(data_out, 0, 0), 6);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_active_bank", int'(active_bank), 0);
      idle(1);
      rst_n = 1'b1;
      idle(1);
      drive_beat(make_vec(5, 0), '1);
      get_out(v);
      chk("post_rst_code5", lane(v, 0, 0), -4);

      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
